// File: rtl/mcdt_pkg.sv
// rtl/mcdt_pkg.sv - shared sizes, arbiter state type and round-robin helper for mcdt_distributor
package mcdt_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int MARGIN_W   = 6;
  localparam int NUM_CH     = 3;
  localparam int ID_W       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // First requester strictly after 'last' in the cyclic order 0->1->2->0.
  function automatic logic [ID_W-1:0] rr_next(input logic [NUM_CH-1:0] req,
                                               input logic [ID_W-1:0]   last);
    logic [ID_W-1:0] cand;
    logic            found;
    rr_next = last;
    cand    = last;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand >= ID_W'(NUM_CH - 1)) ? '0 : cand + ID_W'(1);
      if (!found && req[cand]) begin
        rr_next = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mcdt_distributor_chan_fifo.sv
// rtl/mcdt_distributor_chan_fifo.sv - one channel FIFO with margin, request and ack-driven pop
module chan_fifo
  import mcdt_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [MARGIN_W-1:0] margin_o,
  output logic                req_o,
  input  logic                ack_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                val_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [MARGIN_W-1:0] count_q, count_d;
  logic                req_q, val_q;
  logic [DATA_W-1:0]   data_q;
  logic                push, pop;

  assign ready_o  = (count_q != MARGIN_W'(FIFO_DEPTH));
  assign margin_o = MARGIN_W'(FIFO_DEPTH) - count_q;
  assign push     = valid_i && ready_o;
  assign pop      = ack_i && (count_q != '0);
  assign req_o    = req_q;
  assign data_o   = data_q;
  assign val_o    = val_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + MARGIN_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - MARGIN_W'(1);
    end
  end

  // A word landing in an empty FIFO is advertised one cycle later; the
  // request drops on the very edge that empties the FIFO, so it is never stale.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      val_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_q   <= mem_q[rd_ptr_q];
      end
      val_q   <= pop;
      req_q   <= (count_q != '0) && (count_d != '0);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mcdt_distributor.sv
// rtl/mcdt_distributor.sv - three buffered channels merged round-robin onto one ID-tagged stream
module mcdt_distributor
  import mcdt_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [DATA_W-1:0]   ch0_data_i,
  input  logic                ch0_valid_i,
  output logic                ch0_ready_o,
  output logic [MARGIN_W-1:0] ch0_margin_o,
  input  logic [DATA_W-1:0]   ch1_data_i,
  input  logic                ch1_valid_i,
  output logic                ch1_ready_o,
  output logic [MARGIN_W-1:0] ch1_margin_o,
  input  logic [DATA_W-1:0]   ch2_data_i,
  input  logic                ch2_valid_i,
  output logic                ch2_ready_o,
  output logic [MARGIN_W-1:0] ch2_margin_o,
  output logic [DATA_W-1:0]   mcdt_data_o,
  output logic                mcdt_val_o,
  output logic [ID_W-1:0]     mcdt_id_o
);

  logic [DATA_W-1:0]   ch_data   [NUM_CH];
  logic [MARGIN_W-1:0] ch_margin [NUM_CH];
  logic [DATA_W-1:0]   fifo_data [NUM_CH];
  logic [NUM_CH-1:0]   ch_valid, ch_ready, fifo_req, fifo_val;
  logic [NUM_CH-1:0]   ack_q, ack_d;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                val_q, val_d;
  logic                decide;

  assign ch_data[0]   = ch0_data_i;
  assign ch_data[1]   = ch1_data_i;
  assign ch_data[2]   = ch2_data_i;
  assign ch_valid     = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
  assign ch0_ready_o  = ch_ready[0];
  assign ch1_ready_o  = ch_ready[1];
  assign ch2_ready_o  = ch_ready[2];
  assign ch0_margin_o = ch_margin[0];
  assign ch1_margin_o = ch_margin[1];
  assign ch2_margin_o = ch_margin[2];
  assign mcdt_data_o  = data_q;
  assign mcdt_val_o   = val_q;
  assign mcdt_id_o    = id_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_fifo u_fifo (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .data_i   (ch_data[g]),
      .valid_i  (ch_valid[g]),
      .ready_o  (ch_ready[g]),
      .margin_o (ch_margin[g]),
      .req_o    (fifo_req[g]),
      .ack_i    (ack_q[g]),
      .data_o   (fifo_data[g]),
      .val_o    (fifo_val[g])
    );
  end

  // last_q doubles as the granted channel while in WAIT and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ack_d   = '0;
    data_d  = data_q;
    id_d    = id_q;
    val_d   = 1'b0;
    decide  = 1'b0;
    case (state_q)
      IDLE: decide = 1'b1;
      WAIT: begin
        if (fifo_val[last_q]) begin
          data_d  = fifo_data[last_q];
          id_d    = last_q;
          val_d   = 1'b1;
          state_d = IDLE;
          decide  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (decide && (|fifo_req)) begin
      last_d                        = rr_next(fifo_req, last_q);
      ack_d[rr_next(fifo_req, last_q)] = 1'b1;
      state_d                       = WAIT;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      last_q  <= ID_W'(2);
      ack_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      id_q    <= id_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_mcdt_distributor.sv
// tb/tb_mcdt_distributor.sv - self-checking bench for mcdt_distributor
module tb_mcdt_distributor;

  logic        clk_i  = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] din [3];
  logic        vin [3];
  logic        rdy [3];
  logic [5:0]  mrg [3];
  logic [31:0] mcdt_data_o;
  logic        mcdt_val_o;
  logic [1:0]  mcdt_id_o;

  always #5 clk_i = ~clk_i;

  mcdt_distributor dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .ch0_data_i   (din[0]),
    .ch0_valid_i  (vin[0]),
    .ch0_ready_o  (rdy[0]),
    .ch0_margin_o (mrg[0]),
    .ch1_data_i   (din[1]),
    .ch1_valid_i  (vin[1]),
    .ch1_ready_o  (rdy[1]),
    .ch1_margin_o (mrg[1]),
    .ch2_data_i   (din[2]),
    .ch2_valid_i  (vin[2]),
    .ch2_ready_o  (rdy[2]),
    .ch2_margin_o (mrg[2]),
    .mcdt_data_o  (mcdt_data_o),
    .mcdt_val_o   (mcdt_val_o),
    .mcdt_id_o    (mcdt_id_o)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
  } obs_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [1:0]  exp_id;
    int          exp_lat;
  } sv_t;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  obs_t        out_q [$];
  logic [31:0] sq [3][$];
  logic [31:0] fq [$];
  logic        prev_val;
  int          e, nacc, guard;
  logic        full;
  sv_t         vt [4];
  int          exp_m [4] = '{31, 31, 31, 32};
  logic [1:0]  rr_id [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [31:0] rr_dat [6] = '{32'hA0, 32'hB0, 32'hC0, 32'hA1, 32'hB1, 32'hC1};
  logic [1:0]  sk_id [6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
  logic [31:0] sk_dat [6] = '{32'h50, 32'h70, 32'h51, 32'h71, 32'h0, 32'h0};

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rstn_i && mcdt_val_o) out_q.push_back('{mcdt_id_o, mcdt_data_o, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    for (int c = 0; c < 3; c++) vin[c] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clr_in();
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    out_q.delete();
  endtask

  task automatic chk_seq(input string name, input int n, input logic [1:0] eid [6],
                         input logic [31:0] edat [6], input int first);
    chk($sformatf("%s_count", name), out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      chk($sformatf("%s_id%0d", name, i), out_q[i].id, eid[i]);
      chk($sformatf("%s_data%0d", name, i), out_q[i].data, edat[i]);
      chk($sformatf("%s_cycle%0d", name, i), out_q[i].cyc, first + 2 * i);
    end
  endtask

  task automatic chk_in_order(input string name);
    chk($sformatf("%s_count", name), out_q.size(), fq.size());
    for (int i = 0; i < fq.size() && i < out_q.size(); i++)
      chk($sformatf("%s_word%0d", name, i), out_q[i].data, fq[i]);
  endtask

  task automatic rand_step(input int r0, input int r1, input int r2);
    int   cnt;
    logic v;
    @(negedge clk_i);
    if (mcdt_val_o) begin
      if (mcdt_id_o > 2'd2 || sq[mcdt_id_o].size() == 0) begin
        total++;
        bad++;
        $display("FAIL rand_unexpected_word: id=%0d data=%0h required=a queued word", mcdt_id_o, mcdt_data_o);
      end else begin
        chk("rand_data", mcdt_data_o, sq[mcdt_id_o].pop_front());
      end
    end
    chk("rand_back_to_back", {31'b0, prev_val & mcdt_val_o}, 32'd0);
    prev_val = mcdt_val_o;
    for (int c = 0; c < 3; c++) begin
      cnt = 32 - int'(mrg[c]);
      total++;
      if (!(sq[c].size() == cnt || sq[c].size() == cnt + 1)) begin
        bad++;
        $display("FAIL rand_occupancy ch%0d: fifo count=%0d required model count %0d or one less", c, cnt, sq[c].size());
      end
    end
    for (int c = 0; c < 3; c++) begin
      v = ($urandom_range(0, 99) < ((c == 0) ? r0 : (c == 1) ? r1 : r2));
      vin[c] = v;
      din[c] = $urandom;
      if (v && rdy[c]) sq[c].push_back(din[c]);
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      vin[c] = 1'b0;
      din[c] = '0;
    end
    vt[0] = '{1, 32'hDEADBEEF, 2'd1, 4};
    vt[1] = '{0, 32'h00000001, 2'd0, 4};
    vt[2] = '{2, 32'hFFFFFFFF, 2'd2, 4};
    vt[3] = '{1, 32'h12345678, 2'd1, 4};

    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset_ready%0d", c), rdy[c], 1);
      chk($sformatf("reset_margin%0d", c), mrg[c], 32);
    end
    chk("reset_val", mcdt_val_o, 0);
    chk("reset_id", mcdt_id_o, 0);
    chk("reset_data", mcdt_data_o, 0);
    rstn_i = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      out_q.delete();
      vin[vt[i].ch] = 1'b1;
      din[vt[i].ch] = vt[i].data;
      e = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_i);
        vin[vt[i].ch] = 1'b0;
        chk($sformatf("single%0d_margin_e%0d", i, k), mrg[vt[i].ch], exp_m[k]);
      end
      repeat (4) @(negedge clk_i);
      chk($sformatf("single%0d_pulses", i), out_q.size(), 1);
      if (out_q.size() > 0) begin
        chk($sformatf("single%0d_id", i), out_q[0].id, vt[i].exp_id);
        chk($sformatf("single%0d_data", i), out_q[0].data, vt[i].data);
        chk($sformatf("single%0d_latency", i), out_q[0].cyc - e, vt[i].exp_lat);
      end
    end

    do_reset();
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      vin[c] = 1'b1;
      din[c] = rr_dat[c];
    end
    e = cyc + 1;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) din[c] = rr_dat[c + 3];
    @(negedge clk_i);
    clr_in();
    repeat (18) @(negedge clk_i);
    chk_seq("round_robin", 6, rr_id, rr_dat, e + 4);

    do_reset();
    @(negedge clk_i);
    vin[0] = 1'b1; din[0] = 32'h50;
    vin[2] = 1'b1; din[2] = 32'h70;
    e = cyc + 1;
    @(negedge clk_i);
    din[0] = 32'h51;
    din[2] = 32'h71;
    @(negedge clk_i);
    clr_in();
    repeat (14) @(negedge clk_i);
    chk_seq("skip_empty", 4, sk_id, sk_dat, e + 4);

    do_reset();
    fq.delete();
    nacc = 0;
    guard = 0;
    full = 1'b0;
    while (!full && guard < 300) begin
      @(negedge clk_i);
      guard++;
      if (!rdy[0]) begin
        full = 1'b1;
      end else begin
        vin[0] = 1'b1;
        din[0] = 32'h100 + nacc;
        fq.push_back(din[0]);
        nacc++;
      end
    end
    chk("fill_reached_full", full, 1);
    chk("fill_margin_zero", mrg[0], 0);
    chk("fill_ready_low", rdy[0], 0);
    chk("fill_accepted_at_least_32", nacc >= 32, 1);
    din[0] = 32'h0BAD0BAD;
    @(negedge clk_i);
    clr_in();
    repeat (90) @(negedge clk_i);
    chk_in_order("fill_drain");

    do_reset();
    fq.delete();
    @(negedge clk_i);
    vin[2] = 1'b1; din[2] = 32'hC000; fq.push_back(din[2]);
    @(negedge clk_i);
    din[2] = 32'hC001; fq.push_back(din[2]);
    @(negedge clk_i);
    vin[2] = 1'b0;
    chk("concurrent_margin_start", mrg[2], 30);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      vin[2] = 1'b1;
      din[2] = 32'hC002 + k;
      fq.push_back(din[2]);
      chk($sformatf("concurrent_margin_a%0d", k), mrg[2], 30);
      @(negedge clk_i);
      vin[2] = 1'b0;
      chk($sformatf("concurrent_margin_b%0d", k), mrg[2], 30);
    end
    repeat (20) @(negedge clk_i);
    chk_in_order("concurrent");

    do_reset();
    @(negedge clk_i);
    vin[2] = 1'b1; din[2] = 32'hE0;
    @(negedge clk_i);
    din[2] = 32'hE1;
    @(negedge clk_i);
    din[2] = 32'hE2;
    @(negedge clk_i);
    clr_in();
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    chk("midreset_pre_val", mcdt_val_o, 1);
    chk("midreset_pre_id", mcdt_id_o, 2);
    rstn_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midreset_ready%0d", c), rdy[c], 1);
      chk($sformatf("midreset_margin%0d", c), mrg[c], 32);
    end
    chk("midreset_val", mcdt_val_o, 0);
    chk("midreset_id", mcdt_id_o, 0);
    chk("midreset_data", mcdt_data_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    out_q.delete();
    repeat (10) @(negedge clk_i);
    chk("midreset_no_leftover", out_q.size(), 0);

    do_reset();
    for (int c = 0; c < 3; c++) sq[c].delete();
    prev_val = 1'b0;
    for (int n = 0; n < 400; n++) rand_step(70, 45, 30);
    for (int n = 0; n < 400; n++) rand_step(15, 25, 10);
    for (int n = 0; n < 200; n++) rand_step(0, 0, 0);
    for (int c = 0; c < 3; c++) chk($sformatf("rand_drained%0d", c), sq[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
